// File: rtl/imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : imem_arb
// Purpose  : Two-port arbiter for the 128-bit instruction-memory line-read
//            path. Requester 0 (icache refill) and requester 1 (prefetch /
//            debug line reader) share the RAM and ROM line-read ports. The
//            granted line address is decoded to RAM, ROM or unmapped. Returned
//            data and completion status are registered.
// Config   : IMEM_ARB_RR_EN defined   -> round-robin between the two ports
//            IMEM_ARB_RR_EN undefined -> fixed priority, port 0 always wins
// Ports    : clk, rst               clock, asynchronous active-high reset
//            rN_stb / rN_addr       requester N line request, 26-bit address
//            rN_dout / rN_ack/rN_err  shared line data, completion pulses
//            ram_inst_*             RAM line-read port (25-bit line address)
//            rom_inst_*             ROM line-read port (24-bit line address)
// Revision : 1.0 - initial release
// ============================================================================
module imem_arb (
  input  logic          clk,
  input  logic          rst,
  // requester 0
  input  logic          r0_stb,
  input  logic [25:0]   r0_addr,
  output logic [127:0]  r0_dout,
  output logic          r0_ack,
  output logic          r0_err,
  // requester 1
  input  logic          r1_stb,
  input  logic [25:0]   r1_addr,
  output logic [127:0]  r1_dout,
  output logic          r1_ack,
  output logic          r1_err,
  // RAM line-read port
  output logic          ram_inst_stb,
  output logic [24:0]   ram_inst_addr,
  input  logic [127:0]  ram_inst_dout,
  input  logic          ram_inst_ack,
  input  logic          ram_inst_timeout,
  // ROM line-read port
  output logic          rom_inst_stb,
  output logic [23:0]   rom_inst_addr,
  input  logic [127:0]  rom_inst_dout,
  input  logic          rom_inst_ack,
  input  logic          rom_inst_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_ROM  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Region decode values for address bits [25:24]
  localparam logic [1:0] C_ROM_REGION = 2'b10;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;          // port currently being served
  // Only bits [24:0] of the granted address ever reach a memory port; bit 25
  // is consumed by the decode at grant time and need not be kept.
  logic [24:0]    addr_q, addr_d;
  logic           err_q, err_d;          // completion is an error
  logic [127:0]   data_q, data_d;        // shared line data register
  logic           ram_stb_q, ram_stb_d;
  logic           rom_stb_q, rom_stb_d;

  // --------------------------------------------------------------------------
  // Requester selection
  // --------------------------------------------------------------------------
  logic           req_any;
  logic           sel;                   // port that would win this cycle
  logic [25:0]    sel_addr;
  logic           sel_is_ram;
  logic           sel_is_rom;

`ifdef IMEM_ARB_RR_EN
  // Port granted most recently. Resets to 1 so that port 0 is preferred on
  // the first contended grant.
  logic           last_q, last_d;

  always_comb begin
    if (r0_stb && r1_stb) begin
      sel = ~last_q;
    end else begin
      sel = ~r0_stb;
    end
  end
`else
  // Fixed priority: port 1 is only chosen when port 0 is not requesting.
  always_comb begin
    sel = ~r0_stb;
  end
`endif

  always_comb begin
    req_any    = r0_stb | r1_stb;
    sel_addr   = sel ? r1_addr : r0_addr;
    sel_is_ram = ~sel_addr[25];
    sel_is_rom = (sel_addr[25:24] == C_ROM_REGION);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    data_d    = data_q;
    ram_stb_d = ram_stb_q;
    rom_stb_d = rom_stb_q;
`ifdef IMEM_ARB_RR_EN
    last_d    = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          gnt_d  = sel;
          addr_d = sel_addr[24:0];
`ifdef IMEM_ARB_RR_EN
          // Every grant moves the pointer, unmapped ones included.
          last_d = sel;
`endif
          if (sel_is_ram) begin
            state_d   = ST_RAM;
            ram_stb_d = 1'b1;
            err_d     = 1'b0;
          end else if (sel_is_rom) begin
            state_d   = ST_ROM;
            rom_stb_d = 1'b1;
            err_d     = 1'b0;
          end else begin
            // Unmapped: no memory access, report the error straight away.
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_RAM: begin
        // Ack takes precedence over a simultaneous timeout. ROM responses
        // are not looked at here.
        if (ram_inst_ack) begin
          data_d    = ram_inst_dout;
          err_d     = 1'b0;
          ram_stb_d = 1'b0;
          state_d   = ST_DONE;
        end else if (ram_inst_timeout) begin
          err_d     = 1'b1;
          ram_stb_d = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_ROM: begin
        if (rom_inst_ack) begin
          data_d    = rom_inst_dout;
          err_d     = 1'b0;
          rom_stb_d = 1'b0;
          state_d   = ST_DONE;
        end else if (rom_inst_timeout) begin
          err_d     = 1'b1;
          rom_stb_d = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // One cycle for the requester to see its pulse and drop stb before
        // arbitration resumes; a stb still high here is not looked at.
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        ram_stb_d = 1'b0;
        rom_stb_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
      ram_stb_q <= 1'b0;
      rom_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      data_q    <= data_d;
      ram_stb_q <= ram_stb_d;
      rom_stb_q <= rom_stb_d;
    end
  end

`ifdef IMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Completion pulses are a pure decode of DONE plus registered grant/error,
  // so an asynchronous reset clears them immediately.
  logic done;

  always_comb begin
    done          = (state_q == ST_DONE);
    r0_ack        = done & ~gnt_q & ~err_q;
    r0_err        = done & ~gnt_q &  err_q;
    r1_ack        = done &  gnt_q & ~err_q;
    r1_err        = done &  gnt_q &  err_q;
    r0_dout       = data_q;
    r1_dout       = data_q;
    ram_inst_stb  = ram_stb_q;
    rom_inst_stb  = rom_stb_q;
    ram_inst_addr = addr_q;
    rom_inst_addr = addr_q[23:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arb
// Purpose  : Directed self-checking bench for imem_arb. Inputs are driven and
//            outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arb;

  localparam logic [127:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LINE_B = 128'hFEDCBA9876543210FEDCBA9876543210;
  localparam logic [127:0] LINE_C = 128'h55AA55AA0F0F0F0F33CC33CC12345678;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_stb = 1'b0, r1_stb = 1'b0;
  logic [25:0]   r0_addr = '0, r1_addr = '0;
  logic [127:0]  r0_dout, r1_dout;
  logic          r0_ack, r0_err, r1_ack, r1_err;
  logic          ram_inst_stb, rom_inst_stb;
  logic [24:0]   ram_inst_addr;
  logic [23:0]   rom_inst_addr;
  logic [127:0]  ram_inst_dout = '0, rom_inst_dout = '0;
  logic          ram_inst_ack = 1'b0, ram_inst_timeout = 1'b0;
  logic          rom_inst_ack = 1'b0, rom_inst_timeout = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  imem_arb dut (
    .clk              (clk),
    .rst              (rst),
    .r0_stb           (r0_stb),
    .r0_addr          (r0_addr),
    .r0_dout          (r0_dout),
    .r0_ack           (r0_ack),
    .r0_err           (r0_err),
    .r1_stb           (r1_stb),
    .r1_addr          (r1_addr),
    .r1_dout          (r1_dout),
    .r1_ack           (r1_ack),
    .r1_err           (r1_err),
    .ram_inst_stb     (ram_inst_stb),
    .ram_inst_addr    (ram_inst_addr),
    .ram_inst_dout    (ram_inst_dout),
    .ram_inst_ack     (ram_inst_ack),
    .ram_inst_timeout (ram_inst_timeout),
    .rom_inst_stb     (rom_inst_stb),
    .rom_inst_addr    (rom_inst_addr),
    .rom_inst_dout    (rom_inst_dout),
    .rom_inst_ack     (rom_inst_ack),
    .rom_inst_timeout (rom_inst_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ram_inst_stb, rom_inst_stb, r0_ack, r0_err, r1_ack, r1_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {ram_inst_stb, rom_inst_stb, r0_ack, r0_err, r1_ack, r1_err});
    end
    n_cmp++;
    if (r0_dout !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", r0_dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_read();
    r0_addr = 26'h0000010;
    r0_stb  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_inst_stb !== 1'b1 || ram_inst_addr !== 25'h0000010) begin
      n_bad++;
      $display("FAIL ram_req: stb=%b addr=%h want stb=1 addr=0000010", ram_inst_stb, ram_inst_addr);
    end
    n_cmp++;
    if (rom_inst_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL ram_req_rom_stb: got %b want 0", rom_inst_stb);
    end
    @(negedge clk);
    @(negedge clk);
    ram_inst_dout = LINE_A;
    ram_inst_ack  = 1'b1;
    @(negedge clk);
    ram_inst_ack  = 1'b0;
    ram_inst_dout = '0;
    n_cmp++;
    if ({r0_ack, r0_err, r1_ack, ram_inst_stb, rom_inst_stb} !== 5'b10000) begin
      n_bad++;
      $display("FAIL ram_done_flags: got %b want 10000",
               {r0_ack, r0_err, r1_ack, ram_inst_stb, rom_inst_stb});
    end
    n_cmp++;
    if (r0_dout !== LINE_A) begin
      n_bad++;
      $display("FAIL ram_data: got %h want %h", r0_dout, LINE_A);
    end
    r0_stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r0_ack !== 1'b0 || r0_dout !== LINE_A) begin
      n_bad++;
      $display("FAIL ram_after: ack=%b data=%h want ack=0 data=%h", r0_ack, r0_dout, LINE_A);
    end
  endtask

  task automatic test_rom_read();
    r1_addr = 26'h2000005;
    r1_stb  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rom_inst_stb !== 1'b1 || rom_inst_addr !== 24'h000005 || ram_inst_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL rom_req: rom_stb=%b addr=%h ram_stb=%b want 1 000005 0",
               rom_inst_stb, rom_inst_addr, ram_inst_stb);
    end
    rom_inst_dout = LINE_B;
    rom_inst_ack  = 1'b1;
    @(negedge clk);
    rom_inst_ack  = 1'b0;
    n_cmp++;
    if ({r1_ack, r1_err, r0_ack, rom_inst_stb, ram_inst_stb} !== 5'b10000) begin
      n_bad++;
      $display("FAIL rom_done_flags: got %b want 10000",
               {r1_ack, r1_err, r0_ack, rom_inst_stb, ram_inst_stb});
    end
    n_cmp++;
    if (r1_dout !== LINE_B) begin
      n_bad++;
      $display("FAIL rom_data: got %h want %h", r1_dout, LINE_B);
    end
    r1_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    r0_addr = 26'h3000000;
    r0_stb  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({r0_err, r0_ack, ram_inst_stb, rom_inst_stb} !== 4'b1000) begin
      n_bad++;
      $display("FAIL unmapped_flags: got %b want 1000", {r0_err, r0_ack, ram_inst_stb, rom_inst_stb});
    end
    n_cmp++;
    if (r0_dout !== LINE_B) begin
      n_bad++;
      $display("FAIL unmapped_data: got %h want %h", r0_dout, LINE_B);
    end
    r0_stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r0_err !== 1'b0 || ram_inst_stb !== 1'b0 || rom_inst_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL unmapped_after: err=%b ram=%b rom=%b want 0 0 0", r0_err, ram_inst_stb, rom_inst_stb);
    end
  endtask

  task automatic test_timeout();
    r0_addr = 26'h0000100;
    r0_stb  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_inst_stb !== 1'b1 || ram_inst_addr !== 25'h0000100) begin
      n_bad++;
      $display("FAIL to_req: stb=%b addr=%h want 1 0000100", ram_inst_stb, ram_inst_addr);
    end
    // A ROM ack at the same time belongs to the idle port and must be ignored.
    ram_inst_timeout = 1'b1;
    rom_inst_ack     = 1'b1;
    rom_inst_dout    = LINE_C;
    @(negedge clk);
    ram_inst_timeout = 1'b0;
    rom_inst_ack     = 1'b0;
    n_cmp++;
    if ({r0_err, r0_ack, ram_inst_stb} !== 3'b100) begin
      n_bad++;
      $display("FAIL to_flags: got %b want 100", {r0_err, r0_ack, ram_inst_stb});
    end
    n_cmp++;
    if (r0_dout !== LINE_B) begin
      n_bad++;
      $display("FAIL to_data: got %h want %h", r0_dout, LINE_B);
    end
    r0_stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r0_err !== 1'b0 || ram_inst_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL to_after: err=%b stb=%b want 0 0", r0_err, ram_inst_stb);
    end
  endtask

  task automatic test_ack_wins();
    r1_addr = 26'h0000200;
    r1_stb  = 1'b1;
    @(negedge clk);
    ram_inst_dout    = LINE_C;
    ram_inst_ack     = 1'b1;
    ram_inst_timeout = 1'b1;
    @(negedge clk);
    ram_inst_ack     = 1'b0;
    ram_inst_timeout = 1'b0;
    n_cmp++;
    if ({r1_ack, r1_err} !== 2'b10 || r1_dout !== LINE_C) begin
      n_bad++;
      $display("FAIL ack_wins: ack=%b err=%b data=%h want 1 0 %h", r1_ack, r1_err, r1_dout, LINE_C);
    end
    r1_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic        exp_port;
    logic [24:0] exp_addr;
    logic [127:0] line;
    int          wait_cnt;
    logic        seen;
    r0_addr = 26'h0000020;
    r1_addr = 26'h0000030;
    r0_stb  = 1'b1;
    r1_stb  = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef IMEM_ARB_RR_EN
      exp_port = k[0];
`else
      exp_port = 1'b0;
`endif
      exp_addr = exp_port ? 25'h0000030 : 25'h0000020;
      line     = LINE_C ^ 128'(k + 1);
      seen     = 1'b0;
      wait_cnt = 0;
      while (!seen && wait_cnt < 10) begin
        @(negedge clk);
        if (ram_inst_stb === 1'b1) seen = 1'b1;
        else wait_cnt++;
      end
      n_cmp++;
      if (!seen) begin
        n_bad++;
        $display("FAIL b2b_grant_%0d: no ram stb within 10 cycles", k);
      end else begin
        n_cmp++;
        if (ram_inst_addr !== exp_addr) begin
          n_bad++;
          $display("FAIL b2b_order_%0d: addr=%h want %h", k, ram_inst_addr, exp_addr);
        end
        ram_inst_dout = line;
        ram_inst_ack  = 1'b1;
        @(negedge clk);
        ram_inst_ack  = 1'b0;
        n_cmp++;
        if ({r0_ack, r1_ack} !== (exp_port ? 2'b01 : 2'b10)) begin
          n_bad++;
          $display("FAIL b2b_ack_%0d: r0_ack=%b r1_ack=%b want port %0d", k, r0_ack, r1_ack, exp_port);
        end
        n_cmp++;
        if (r0_dout !== line) begin
          n_bad++;
          $display("FAIL b2b_data_%0d: got %h want %h", k, r0_dout, line);
        end
      end
    end
    r0_stb = 1'b0;
    r1_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    r0_addr = 26'h0000040;
    r0_stb  = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_inst_stb !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_req: stb=%b want 1", ram_inst_stb);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ram_inst_stb, rom_inst_stb, r0_ack, r0_err} !== 4'b0 || r0_dout !== 128'h0) begin
      n_bad++;
      $display("FAIL rmid_async: flags=%b data=%h want 0000 0",
               {ram_inst_stb, rom_inst_stb, r0_ack, r0_err}, r0_dout);
    end
    r0_stb       = 1'b0;
    ram_inst_ack = 1'b1;
    @(negedge clk);
    ram_inst_ack = 1'b0;
    rst          = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ram_inst_stb, r0_ack, r0_err, r1_ack, r1_err} !== 5'b0) begin
        n_bad++;
        $display("FAIL rmid_after_%0d: got %b want 00000", c,
                 {ram_inst_stb, r0_ack, r0_err, r1_ack, r1_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_rom_read();
    test_unmapped();
    test_timeout();
    test_ack_wins();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_arb.md
# imem_arb

Two-port arbiter for the 128-bit instruction-memory line-read path. It sits between the instruction-fetch refill logic and the RAM/ROM line-read ports. It shares the RAM and ROM line-read ports between requester 0 (icache refill) and requester 1 (prefetch/debug line reader). It also decodes each line address to RAM, ROM or unmapped, and registers returned data and completion status.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- r0_stb  in  1  requester 0 read request; held until r0_ack or r0_err
- r0_addr  in  26  requester 0 line address (byte address bits [29:4])
- r0_dout  out  128  line data; valid while r0_ack=1
- r0_ack  out  1  one-cycle completion pulse
- r0_err  out  1  one-cycle error pulse (timeout or unmapped)
- r1_stb, r1_addr, r1_dout, r1_ack, r1_err  same as requester 0
- ram_inst_stb  out  1  RAM line request
- ram_inst_addr  out  25  RAM line address
- ram_inst_dout  in  128  RAM line data
- ram_inst_ack  in  1  RAM completion
- ram_inst_timeout  in  1  RAM timeout
- rom_inst_stb  out  1  ROM line request
- rom_inst_addr  out  24  ROM line address
- rom_inst_dout  in  128  ROM line data
- rom_inst_ack  in  1  ROM completion
- rom_inst_timeout  in  1  ROM timeout

## Operation
- Address decode of the granted address a[25:0]:
  - a[25]=0 → RAM, ram_inst_addr=a[24:0].
  - a[25:24]=2'b10 → ROM, rom_inst_addr=a[23:0].
  - a[25:24]=2'b11 → unmapped.
- FSM states: IDLE, RAM, ROM, DONE.
- IDLE: if any stb, grant one requester and latch its address and grant id.
  - Mapped address → RAM or ROM state.
  - Unmapped address → DONE with err flag set.
- RAM/ROM: the matching mem stb is 1 (registered output).
  - Mem ack → latch mem dout into the data register, clear err flag, go to DONE.
  - Mem timeout → set err flag, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
  - No ack/timeout → stay.
- DONE: pulse the granted requester's ack (err flag=0) or err (err flag=1), then go to IDLE.
  - DONE exists so the requester can drop stb before re-arbitration.
- r0_dout and r1_dout are both driven from the shared data register.
  - The register holds its value until the next mem ack.
  - After an error, the register keeps the previous line.
- A requester dropping stb mid-transaction is illegal. The arbiter completes the transaction and pulses ack/err anyway.
- The mem ack/timeout inputs of the port not currently strobed are ignored.

## Timing
- Reset values: ram_inst_stb=0, rom_inst_stb=0, r0_ack/r0_err/r1_ack/r1_err=0, data register=0, state=IDLE, RR pointer prefers port 0.
- Reset mid-transaction: all outputs go low immediately (asynchronous); the in-flight request is abandoned.
- Mapped request, with stb sampled high at edge N (state IDLE):
  - mem stb=1 from cycle N+1.
  - Mem ack sampled at edge K → mem stb=0 and requester ack=1 in cycle K+1.
  - IDLE in cycle K+2.
  - Minimum request-to-ack latency: 2 cycles plus memory latency.
- Unmapped request: err=1 in the cycle after the grant edge; no mem stb is issued.
- Back-to-back: a stb still high in DONE is ignored. A stb held high in IDLE at K+2 starts a new grant.
- Mem stb is never asserted on both RAM and ROM at once.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests in IDLE, the port not granted last wins.
  - The pointer updates on every grant, including unmapped grants.
- IMEM_ARB_RR_EN undefined: fixed priority; port 0 always wins simultaneous requests, and port 1 can starve.

## Test plan
- Single RAM read: r0_stb, r0_addr=26'h0000010, RAM acks 3 cycles after stb with 128'h0123…CDEF.
  - ram_inst_addr=25'h0000010.
  - r0_ack one cycle after ram_inst_ack, r0_dout=128'h0123…CDEF.
  - rom_inst_stb stays 0.
- ROM read: r1_addr=26'h2000005.
  - rom_inst_addr=24'h000005.
  - r1_ack=1, r1_err=0; ram_inst_stb stays 0.
- Unmapped: r0_addr=26'h3000000.
  - r0_err pulses 1 cycle after grant; no mem stb; data register unchanged.
- Timeout: RAM asserts ram_inst_timeout → r0_err=1 for one cycle, r0_ack=0, next IDLE.
- Contention: r0 and r1 asserted together, held through 4 completions.
  - RR_EN grant order: 0,1,0,1.
  - Without RR_EN: 0,0,0,0 while r0 re-requests.
- Reset mid-transaction: assert rst while ram_inst_stb=1.
  - ram_inst_stb=0 the same cycle; no ack/err follows after reset release.
